// File: rtl/pcie_tx_pkg.sv
// Shared types and constants for the PCIe posted Memory Write transmit engine.
// Holds the TLP format/type code, FSM state encoding and the data-credit helper.
package pcie_tx_pkg;

  localparam logic [7:0] FMT_TYPE_MWR32 = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_REQ,
    ST_HDR,
    ST_DATA
  } state_t;

  localparam int         HDR_WORDS = 6;
  localparam logic [2:0] HDR_W0    = 3'd0;
  localparam logic [2:0] HDR_W1    = 3'd1;
  localparam logic [2:0] HDR_W2    = 3'd2;
  localparam logic [2:0] HDR_W3    = 3'd3;
  localparam logic [2:0] HDR_W4    = 3'd4;
  localparam logic [2:0] HDR_W5    = 3'd5;

  // One posted data credit covers 4 DWs of payload.
  function automatic logic [11:0] need_pd(input logic [11:0] len_dw);
    return (len_dw + 12'd3) >> 2;
  endfunction

endpackage

// File: rtl/pcie_tx_pbuf.sv
// Single-clock payload buffer: 16-bit words, independent write/read pointers,
// registered read port so the array maps onto block RAM.
module pcie_tx_pbuf #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_wr_en,
  input  logic [15:0] i_wr_data,
  input  logic        i_rd_en,
  output logic [15:0] o_rd_data
);

  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Array storage kept free of reset so it stays inferable as RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[r_rd_ptr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pcie_tx_mwr_sender.sv
// Posted MWr TLP sender: buffers one payload, waits for posted credits, then
// handshakes with the core and streams a 3DW header plus payload on the VC0 TX bus.
module pcie_tx_mwr_sender import pcie_tx_pkg::*; #(
  parameter int MAX_LEN_DW = 32,
  parameter int LW         = 8
) (
  input  logic          sys_clk_125,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_addr,
  input  logic [LW-1:0] cmd_len_dw,
  input  logic          data_valid,
  output logic          data_ready,
  input  logic [15:0]   data_in,
  input  logic [7:0]    bus_num,
  input  logic [4:0]    dev_num,
  input  logic [2:0]    func_num,
  output logic          tx_req_vc0,
  input  logic          tx_rdy_vc0,
  output logic [15:0]   tx_data_vc0,
  output logic          tx_st_vc0,
  output logic          tx_end_vc0,
  output logic          tx_nlfy_vc0,
  input  logic [8:0]    tx_ca_ph_vc0,
  input  logic [12:0]   tx_ca_pd_vc0,
  input  logic          tx_ca_p_recheck_vc0,
  output logic          busy,
  output logic          done,
  output logic          len_err,
  output logic          proto_err
);

  localparam int BUF_DEPTH = 2 * MAX_LEN_DW;
  localparam int CW        = $clog2(2 * MAX_LEN_DW + HDR_WORDS) + 1;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [LW-1:0] r_len;
  logic [31:2]   r_addr;
  logic          r_done, r_len_err, r_proto_err;
  logic          w_done_next, w_len_err_next, w_latch;
  logic          w_len_legal, w_credit_ok;
  logic          w_buf_clr, w_buf_wr, w_buf_rd;
  logic [15:0]   w_buf_rdata, w_hdr_word;
  logic [CW-1:0] w_nwords;
  logic [7:0]    w_be;
  logic          w_unused;

  assign w_unused    = ^cmd_addr[1:0];
  assign w_nwords    = CW'(r_len) << 1;
  assign w_len_legal = (cmd_len_dw != '0) && (cmd_len_dw <= LW'(MAX_LEN_DW));
  assign w_be        = (r_len == LW'(1)) ? 8'h0F : 8'hFF;
  assign w_credit_ok = !tx_ca_p_recheck_vc0
                     && (tx_ca_ph_vc0[8] || (tx_ca_ph_vc0[7:0] != 8'd0))
                     && (tx_ca_pd_vc0[12] || (tx_ca_pd_vc0[11:0] >= need_pd(12'(r_len))));

  pcie_tx_pbuf #(.DEPTH(BUF_DEPTH)) u_pbuf (
    .clk       (sys_clk_125),
    .rst       (rst),
    .i_clr     (w_buf_clr),
    .i_wr_en   (w_buf_wr),
    .i_wr_data (data_in),
    .i_rd_en   (w_buf_rd),
    .o_rd_data (w_buf_rdata)
  );

  always_comb begin
    w_hdr_word = '0;
    case (r_cnt[2:0])
      HDR_W0:  w_hdr_word = {FMT_TYPE_MWR32, 8'h00};
      HDR_W1:  w_hdr_word = {6'b0, 10'(r_len)};
      HDR_W2:  w_hdr_word = {bus_num, dev_num, func_num};
      HDR_W3:  w_hdr_word = {8'h00, w_be};
      HDR_W4:  w_hdr_word = r_addr[31:16];
      HDR_W5:  w_hdr_word = {r_addr[15:2], 2'b00};
      default: w_hdr_word = '0;
    endcase
  end

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_done      <= 1'b0;
      r_len_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_done    <= w_done_next;
      r_len_err <= w_len_err_next;
      if (w_latch) begin
        r_len  <= cmd_len_dw;
        r_addr <= cmd_addr[31:2];
      end
      if ((r_state == ST_HDR || r_state == ST_DATA) && !tx_rdy_vc0)
        r_proto_err <= 1'b1;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_latch        = 1'b0;
    w_len_err_next = 1'b0;
    w_done_next    = 1'b0;
    w_buf_clr      = 1'b0;
    w_buf_wr       = 1'b0;
    w_buf_rd       = 1'b0;
    cmd_ready      = 1'b0;
    data_ready     = 1'b0;
    tx_req_vc0     = 1'b0;
    tx_st_vc0      = 1'b0;
    tx_end_vc0     = 1'b0;
    tx_data_vc0    = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_len_legal) begin
            w_latch      = 1'b1;
            w_buf_clr    = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ST_LOAD;
          end else begin
            w_len_err_next = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        data_ready = 1'b1;
        if (data_valid) begin
          w_buf_wr = 1'b1;
          if (r_cnt == w_nwords - CW'(1)) begin
            w_cnt_next   = '0;
            w_state_next = ST_CHECK;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (w_credit_ok) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        tx_req_vc0 = 1'b1;
        if (tx_rdy_vc0) begin
          w_cnt_next   = '0;
          w_state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        tx_st_vc0   = (r_cnt == '0);
        tx_data_vc0 = w_hdr_word;
        // Prefetch the first payload word during the last header word.
        if (r_cnt == CW'(HDR_WORDS - 1)) begin
          w_buf_rd     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_DATA;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_DATA: begin
        tx_data_vc0 = w_buf_rdata;
        if (r_cnt == w_nwords - CW'(1)) begin
          tx_end_vc0   = 1'b1;
          w_done_next  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end else begin
          w_buf_rd   = 1'b1;
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign tx_nlfy_vc0 = 1'b0;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign len_err     = r_len_err;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_pcie_tx_mwr_sender.sv
// Scoreboard bench for pcie_tx_mwr_sender: stimulus pushes the expected TLP word
// stream, an independent monitor pops and compares whenever the DUT transmits.
module tb_pcie_tx_mwr_sender;

  localparam int MAX = 32;
  localparam int LW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [31:0]   cmd_addr = '0;
  logic [LW-1:0] cmd_len_dw = '0;
  logic          data_valid = 1'b0, data_ready;
  logic [15:0]   data_in = '0;
  logic [7:0]    bus_num = '0;
  logic [4:0]    dev_num = '0;
  logic [2:0]    func_num = '0;
  logic          tx_req_vc0, tx_rdy_vc0 = 1'b0;
  logic [15:0]   tx_data_vc0;
  logic          tx_st_vc0, tx_end_vc0, tx_nlfy_vc0;
  logic [8:0]    tx_ca_ph_vc0 = 9'h100;
  logic [12:0]   tx_ca_pd_vc0 = 13'h1000;
  logic          tx_ca_p_recheck_vc0 = 1'b0;
  logic          busy, done, len_err, proto_err;

  always #5 clk = ~clk;

  pcie_tx_mwr_sender #(.MAX_LEN_DW(MAX), .LW(LW)) dut (
    .sys_clk_125(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len_dw(cmd_len_dw),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
    .tx_req_vc0(tx_req_vc0), .tx_rdy_vc0(tx_rdy_vc0), .tx_data_vc0(tx_data_vc0),
    .tx_st_vc0(tx_st_vc0), .tx_end_vc0(tx_end_vc0), .tx_nlfy_vc0(tx_nlfy_vc0),
    .tx_ca_ph_vc0(tx_ca_ph_vc0), .tx_ca_pd_vc0(tx_ca_pd_vc0),
    .tx_ca_p_recheck_vc0(tx_ca_p_recheck_vc0),
    .busy(busy), .done(done), .len_err(len_err), .proto_err(proto_err)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        st;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   in_pkt  = 0;
  bit   exp_done = 0;
  bit   exp_proto = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: one expected word per transmitted cycle, done one cycle after the last.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt   = 0;
      exp_done = 0;
    end else begin
      if (exp_done || done) chk("done_pulse", done, exp_done);
      exp_done = 0;
      if (tx_st_vc0) in_pkt = 1;
      if (in_pkt) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h with no expected word", tx_data_vc0);
          in_pkt = 0;
        end else begin
          mon_e = exp_q.pop_front();
          chk("tlp_word", {tx_data_vc0, tx_st_vc0, tx_end_vc0}, {mon_e.data, mon_e.st, mon_e.en});
          exp_done = mon_e.en;
          if (mon_e.en || tx_end_vc0) in_pkt = 0;
        end
      end else begin
        chk("idle_bus", {tx_end_vc0, tx_data_vc0}, 17'h0);
      end
    end
  end

  task automatic bad_len(input int len);
    cmd_len_dw = LW'(len);
    cmd_addr   = $urandom;
    cmd_valid  = 1'b1;
    chk("bad_len_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("len_err_pulse", len_err, 1);
    @(posedge clk); #1;
    chk("len_err_clear", len_err, 0);
    repeat (3) begin
      chk("bad_len_quiet", {data_ready, tx_req_vc0, busy, cmd_ready}, 4'b0001);
      @(posedge clk); #1;
    end
  endtask

  // mode 0: random sufficient credits, 1: data-credit stall, 2: recheck held high
  task automatic run_cmd(input logic [31:0] addr, input int len, input int rdy_dly,
                         input int mode, input int drop_at, input int rst_at);
    logic [15:0] pay[$];
    int need, idx, guard, i;
    bit rdy_now;
    need = (len + 3) / 4;
    for (int k = 0; k < 2 * len; k++) pay.push_back(16'($urandom));
    exp_q.push_back('{data: 16'h4000, st: 1'b1, en: 1'b0});
    exp_q.push_back('{data: 16'(len), st: 1'b0, en: 1'b0});
    exp_q.push_back('{data: {bus_num, dev_num, func_num}, st: 1'b0, en: 1'b0});
    exp_q.push_back('{data: (len == 1) ? 16'h000F : 16'h00FF, st: 1'b0, en: 1'b0});
    exp_q.push_back('{data: addr[31:16], st: 1'b0, en: 1'b0});
    exp_q.push_back('{data: {addr[15:2], 2'b00}, st: 1'b0, en: 1'b0});
    for (int k = 0; k < 2 * len; k++)
      exp_q.push_back('{data: pay[k], st: 1'b0, en: (k == 2 * len - 1)});

    tx_ca_p_recheck_vc0 = 1'b0;
    if (mode == 1) begin
      tx_ca_ph_vc0 = 9'd1;
      tx_ca_pd_vc0 = 13'd7;
    end else begin
      case ($urandom_range(0, 2))
        0: begin tx_ca_ph_vc0 = 9'h100 | 9'($urandom_range(0, 255)); tx_ca_pd_vc0 = 13'h1000 | 13'($urandom_range(0, 4095)); end
        1: begin tx_ca_ph_vc0 = 9'd1; tx_ca_pd_vc0 = 13'(need); end
        default: begin tx_ca_ph_vc0 = 9'($urandom_range(1, 255)); tx_ca_pd_vc0 = 13'($urandom_range(need, 4095)); end
      endcase
      if (mode == 2) tx_ca_p_recheck_vc0 = 1'b1;
    end

    cmd_addr   = addr;
    cmd_len_dw = LW'(len);
    cmd_valid  = 1'b1;
    guard = 0;
    do begin
      rdy_now = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy_now && guard < 50);
    cmd_valid = 1'b0;
    if (!rdy_now) begin timeout("cmd_accept"); return; end

    idx = 0;
    guard = 0;
    while (idx < 2 * len && guard < 2000) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = pay[idx];
      rdy_now    = data_ready;
      @(posedge clk); #1;
      if (data_valid && rdy_now) idx++;
      guard++;
    end
    data_valid = 1'b0;
    if (idx < 2 * len) begin timeout("payload_load"); return; end

    if (mode == 1) begin
      repeat (5) begin
        chk("credit_stall", {tx_req_vc0, busy}, 2'b01);
        @(posedge clk); #1;
      end
      tx_ca_pd_vc0 = 13'd8;
      @(posedge clk); #1;
      chk("req_after_credit", tx_req_vc0, 1);
    end else if (mode == 2) begin
      repeat (3) begin
        chk("recheck_hold", tx_req_vc0, 0);
        @(posedge clk); #1;
      end
      tx_ca_p_recheck_vc0 = 1'b0;
      chk("recheck_fall_no_req", tx_req_vc0, 0);
      @(posedge clk); #1;
      chk("req_after_recheck", tx_req_vc0, 1);
    end

    guard = 0;
    while (!tx_req_vc0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!tx_req_vc0) begin timeout("tx_req"); return; end
    if (mode == 0) chk("req_latency", guard, 1);
    repeat (rdy_dly) begin @(posedge clk); #1; end
    tx_rdy_vc0 = 1'b1;
    @(posedge clk); #1;

    i = 0;
    while (!tx_end_vc0 && i < 400) begin
      if (i == rst_at) begin
        rst = 1'b1;
        tx_rdy_vc0 = 1'b0;
        #1;
        chk("rst_outputs", {tx_req_vc0, tx_st_vc0, tx_end_vc0, cmd_ready, busy, data_ready, tx_data_vc0},
            {6'b000100, 16'h0000});
        exp_q.delete();
        exp_proto = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_proto_clear", proto_err, 0);
        return;
      end
      tx_rdy_vc0 = (i != drop_at);
      if (i == drop_at) exp_proto = 1;
      @(posedge clk); #1;
      i++;
    end
    if (!tx_end_vc0) begin timeout("tx_end"); tx_rdy_vc0 = 1'b0; return; end
    chk("tx_end_offset", i, 5 + 2 * len);
    @(posedge clk); #1;
    tx_rdy_vc0 = 1'b0;
    chk("proto_err", proto_err, exp_proto);
    chk("cmd_ready_return", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_in_rst",
        {cmd_ready, data_ready, tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, busy, done, len_err, proto_err, tx_data_vc0},
        {10'b1000000000, 16'h0000});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs_after",
        {cmd_ready, data_ready, tx_req_vc0, tx_st_vc0, tx_end_vc0, tx_nlfy_vc0, busy, done, len_err, proto_err, tx_data_vc0},
        {10'b1000000000, 16'h0000});

    bus_num = 8'd1; dev_num = 5'd2; func_num = 3'd3;
    tx_ca_ph_vc0 = 9'h100; tx_ca_pd_vc0 = 13'h1000;
    run_cmd(32'h1000_0004, 1, 2, 0, -1, -1);

    bus_num = $urandom; dev_num = $urandom; func_num = $urandom;
    run_cmd($urandom, MAX, 1, 1, -1, -1);
    run_cmd($urandom, $urandom_range(1, MAX), 0, 2, -1, -1);

    bad_len(0);
    bad_len(MAX + 1);

    run_cmd($urandom, 8, 1, 0, 10, -1);
    run_cmd($urandom, 3, 0, 0, -1, -1);
    run_cmd($urandom, 16, 0, 0, -1, 12);
    run_cmd(32'hFFFF_FFFF, MAX, 3, 0, -1, -1);

    for (int t = 0; t < 25; t++) begin
      bus_num = $urandom; dev_num = $urandom; func_num = $urandom;
      run_cmd($urandom, $urandom_range(1, MAX), $urandom_range(0, 3), 0, -1, -1);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
